// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per
// clock, starting at the least significant chunk. A registered carry links
// consecutive chunks the same way a ripple chain links full-adder stages.
// Operands arrive and results leave over valid/ready handshakes.
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [KW-1:0]    K_ZERO     = KW'(0);
   localparam logic [KW-1:0]    K_ONE      = KW'(1);
   localparam logic [KW-1:0]    K_LAST     = KW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Adds one chunk plus carry. Returns {signed overflow, carry out, sum}.
   // The carry into the chunk MSB is recovered as sum_msb ^ x_msb ^ y_msb, so
   // overflow is that carry XOR the chunk carry out; it is only meaningful
   // for the most significant chunk.
   function automatic logic [CHUNK+1:0] chunk_add(
      input logic [CHUNK-1:0] x,
      input logic [CHUNK-1:0] y,
      input logic             c
   );
      logic [CHUNK:0] full;
      logic           msb_carry;
      full      = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
      msb_carry = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];
      return {msb_carry ^ full[CHUNK], full[CHUNK], full[CHUNK-1:0]};
   endfunction

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] s_r;
   logic             carry_r;
   logic             cout_r;
   logic             ovf_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [KW-1:0]    k_r;

   logic             in_ready_s;
   logic             accept_s;
   logic [31:0]      base_s;
   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [CHUNK+1:0] add_s;
   logic             last_s;
   logic [WIDTH-1:0] s_next_s;

   // Operand acceptance: when idle, or when the finished result is taken
   // by the consumer in this same cycle (back-to-back operation).
   always_comb begin
      in_ready_s = 1'b0;
      if (state_r == IDLE) begin
         in_ready_s = 1'b1;
      end else if (state_r == DONE) begin
         in_ready_s = out_ready;
      end else begin
         in_ready_s = 1'b0;
      end
      accept_s = in_valid && in_ready_s;
   end

   // Chunk datapath: pick chunk k of both operands, add with the running
   // carry and merge the chunk sum into the result word.
   always_comb begin
      base_s    = 32'(k_r) * 32'(CHUNK);
      a_chunk_s = CHUNK'(a_r >> base_s);
      b_chunk_s = CHUNK'(b_r >> base_s);
      add_s     = chunk_add(a_chunk_s, b_chunk_s, carry_r);
      last_s    = (k_r == K_LAST);
      s_next_s  = (s_r & ~(CHUNK_MASK << base_s))
                | (WIDTH'(add_s[CHUNK-1:0]) << base_s);
   end

   // Operation sequencing: accept, ripple one chunk per cycle, hold the
   // result until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         s_r         <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         k_r         <= K_ZERO;
      end else if (accept_s) begin
         // Subtraction is A + ~B + 1; a set cin then removes one more.
         state_r     <= RUN;
         a_r         <= A;
         b_r         <= sub ? ~B : B;
         carry_r     <= cin ^ sub;
         k_r         <= K_ZERO;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
            RUN: begin
               s_r     <= s_next_s;
               carry_r <= add_s[CHUNK];
               if (last_s) begin
                  cout_r      <= add_s[CHUNK];
                  ovf_r       <= add_s[CHUNK+1];
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= DONE;
               end else begin
                  k_r <= k_r + K_ONE;
               end
            end
            DONE: begin
               // Result registers are left untouched on handoff.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign S         = s_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock, from the LSB chunk upward.
- A registered carry links consecutive chunks, the same way the ripple chain links full-adder stages.
- Operands are accepted and results returned over valid/ready handshakes. The block sits between an operand producer and a result consumer in the datapath, where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle (1..WIDTH).
- NCHUNK, WIDTH/CHUNK, derived (localparam), number of compute cycles per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A, B, cin, sub are valid.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A (unsigned or two's complement).
- B  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  0 = add, 1 = subtract.
- S  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.
- out_valid  output  1  S, cout, ovf are valid.
- out_ready  input  1  consumer takes the result this cycle.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - S, cout, ovf, out_valid and busy are 0; in_ready is 1 after reset releases.
  - Operand and carry registers are cleared.
  - Takes effect immediately regardless of state, including mid-RUN. The in-flight operation is discarded and no result is ever emitted for it.
- States: IDLE, RUN, DONE.
- Accept:
  - Happens on a rising edge with in_valid && in_ready.
  - Registers A, B' = sub ? ~B : B, and carry = cin ^ sub (sub=1, cin=0 gives A-B; sub=1, cin=1 gives A-B-1).
  - Clears chunk index k to 0 and moves to RUN.
- RUN:
  - Each cycle computes {c, S[k*CHUNK +: CHUNK]} = A_chunk + B'_chunk + carry, then stores c into carry and increments k.
  - On the edge that completes chunk NCHUNK-1:
    - cout = final carry.
    - ovf = carry into MSB XOR carry out of MSB, computed inside the last chunk.
    - out_valid = 1; state moves to DONE.
- Latency: out_valid rises exactly NCHUNK clock edges after the accept edge. For NCHUNK=1, out_valid rises one edge after accept.
- While in RUN:
  - S may change chunk by chunk and must not be sampled by the consumer.
  - in_ready = 0; A/B/cin/sub inputs are ignored.
- DONE:
  - S, cout, ovf held stable while out_valid && !out_ready, for any number of cycles.
  - The result is consumed on the edge where out_valid && out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready and allows back-to-back operations.
- DONE with out_ready=1 and in_valid=1 on the same edge: the result is consumed, new operands are accepted, and the state goes to RUN with out_valid=0. No idle bubble.
- DONE with out_ready=1 and in_valid=0: out_valid goes to 0 and the state goes to IDLE. S/cout/ovf keep their last values; they are not cleared.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - No result bits are lost other than cout.
  - Chunk boundaries are invisible: the result is bit-identical to a single WIDTH-bit add of A + B' + (cin^sub).

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Add 0x00FF + 0x0001, cin=0 -> S=0x0100, cout=0, ovf=0; out_valid exactly 4 edges after accept; in_ready=0 and busy=1 during those 4 cycles.
- Add 0xFFFF + 0x0001 and 0x7FFF + 0x0001 -> first S=0x0000, cout=1, ovf=0; second S=0x8000, cout=0, ovf=1 (carry crosses every chunk boundary).
- Subtract 0x0005 - 0x0007, sub=1, cin=0 -> S=0xFFFE, cout=0 (borrow), ovf=0; then 0x8000 - 0x0001 -> S=0x7FFF, cout=1, ovf=1.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles after out_valid rises -> S, cout, ovf and out_valid stay stable; in_valid pulses are ignored (in_ready=0).
  - Then assert out_ready together with in_valid (0x1234 + 0x1111) -> back-to-back accept; next result S=0x2345 after 4 edges.
- Reset mid-operation: pull rst_n low asynchronously (between clock edges) during the 2nd RUN cycle -> all outputs 0 immediately, state IDLE, no out_valid ever emitted for that operation; the next operation 0x0003 + 0x0004 -> S=0x0007.
- Parameter sweep:
  - WIDTH=8, CHUNK=8 (NCHUNK=1) and WIDTH=8, CHUNK=1 (NCHUNK=8), 1000 random add/sub vectors each.
  - Results must match a reference model of A + (sub ? ~B : B) + (cin ^ sub) modulo 2^WIDTH.
  - Latency must be 1 and 8 respectively.
